mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares the team's 4:1 one-bit multiplexer between four requesters. It samples a 4-bit request vector and issues a registered one-hot grant. It drives the mux select lines S0/S1 to match the grant and forwards the granted source bit on OUT. Each grant is limited to a burst of HOLD_MAX cycles whenever other requesters are waiting. The block sits directly in front of the mux datapath and is the only driver of its select lines.

## Interface
- HOLD_MAX, default 4: maximum consecutive granted cycles while another requester is pending; legal range 1..15.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  request vector; REQ[0]..REQ[3] request sources A..D.
- A, B, C, D  input  1 each  data sources.
- GNT  output  4  registered one-hot grant; all zeros when idle.
- S0, S1  output  1 each  registered mux selects.
- OUT  output  1  granted source bit, combinational from A..D through the selects, forced to 0 when BUSY=0.
- BUSY  output  1  registered; high when GNT is nonzero.

## Operation
- Select encoding (fixed by the mux): A = {S0,S1}=00, B = 01, C = 10, D = 11. Index i maps to S0=i[1], S1=i[0].
- State: two-state FSM (IDLE, GRANT), 2-bit last-grant pointer PTR, burst counter CNT of width clog2(HOLD_MAX+1).
- Reset values: GNT=0000, S0=0, S1=0, BUSY=0, OUT=0, PTR=3, CNT=0, state IDLE.
- Round-robin search starts at PTR+1 (mod 4) and wraps. The first set REQ bit wins.
- IDLE:
  - If REQ=0000, stay in IDLE. Selects hold their last values.
  - Otherwise grant the winner g: GNT=1<<g, selects=g, PTR=g, CNT=0, go to GRANT.
- GRANT (current grant g), evaluated each edge:
  - REQ[g]=0 and other requests pending: hand off to the next winner in the same edge, with zero idle cycles.
  - REQ[g]=0 and no other requests: go to IDLE, GNT=0000.
  - REQ[g]=1 and CNT=HOLD_MAX-1 and another REQ bit set: preempt. Grant the next winner after g; g is excluded.
  - REQ[g]=1 and CNT=HOLD_MAX-1 and no other request: keep g, CNT=0.
  - Otherwise keep g, CNT=CNT+1.
- Every new grant sets CNT=0 and PTR to the new index.
- A requester dropping and re-raising REQ in the same cycle it lost grant waits for its next round-robin turn.

## Timing
- Latency from REQ sampled high to GNT high is 1 cycle.
- OUT tracks A..D with zero cycles of latency once selects are registered.
- Maximum wait for any continuously asserted request is 3×HOLD_MAX cycles plus 1.
- RST asserted mid-burst: on the next edge all outputs return to reset values, regardless of REQ.
- GNT, S0/S1 and BUSY always change on the same edge. There is never a cycle where GNT and the selects disagree.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - Adds input port LOCK (1 bit).
  - While in GRANT with REQ[g]=1 and LOCK=1, preemption is suppressed. CNT saturates at HOLD_MAX-1.
  - When LOCK deasserts with CNT saturated and others pending, the block rotates on the next edge.
- MUX_ARB_LOCK_EN undefined: no LOCK port; behaviour exactly as in Operation.

## Test plan
- Reset, then REQ=0000 for 5 cycles -> GNT=0000, BUSY=0, OUT=0, S0=S1=0 throughout.
- REQ=0100 (C), C=1 -> one cycle later GNT=0100, S0=1, S1=0, BUSY=1, OUT=1. Drop REQ -> next cycle GNT=0000, OUT=0.
- REQ=1111 held with HOLD_MAX=4 -> GNT sequence is 0001 for 4 cycles, 0010 for 4, 0100 for 4, 1000 for 4, then back to 0001.
- GNT=0001, REQ goes from 0001 to 1000 in one cycle -> next edge GNT=1000, S0=1, S1=1, with no idle cycle.
- REQ=0010 alone for 10 cycles -> GNT stays 0010 the whole time; CNT wraps to 0 every 4 cycles with no glitch on GNT.
- Mid-burst RST with REQ=1111 -> next edge GNT=0000, BUSY=0. After RST releases, the first grant is 0001, since PTR=3.
- Macro build: LOCK=1, REQ=0011 with A granted -> A is held 10 cycles. Drop LOCK -> next edge GNT=0010.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundles the request/data/grant signals that connect mux_rr_arbiter to its requesters.
// Ports: REQ[3:0], A..D (sources), LOCK (only with MUX_ARB_LOCK_EN) toward the arbiter;
//        GNT[3:0], S0, S1, OUT, BUSY back from it. No clock inside: CLK/RST stay plain ports.
interface mux_rr_arbiter_if;
  logic [3:0] REQ;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic [3:0] GNT;
  logic       S0;
  logic       S1;
  logic       OUT;
  logic       BUSY;
`ifdef MUX_ARB_LOCK_EN
  logic       LOCK;

  // Requester side: drives requests, data and lock, observes grant.
  modport master (
    output REQ, A, B, C, D, LOCK,
    input  GNT, S0, S1, OUT, BUSY
  );

  // Arbiter side.
  modport slave (
    input  REQ, A, B, C, D, LOCK,
    output GNT, S0, S1, OUT, BUSY
  );
`else
  // Requester side: drives requests and data, observes grant.
  modport master (
    output REQ, A, B, C, D,
    input  GNT, S0, S1, OUT, BUSY
  );

  // Arbiter side.
  modport slave (
    input  REQ, A, B, C, D,
    output GNT, S0, S1, OUT, BUSY
  );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Purpose: round-robin arbiter owning the select lines of a 4:1 one-bit mux, bursts capped at HOLD_MAX.
// Latency: REQ sampled high -> registered GNT/S0/S1/BUSY one cycle later; OUT is combinational from A..D.
// Backpressure: none; a requester waits for its turn (bounded by 3*HOLD_MAX+1 cycles) while REQ stays high.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   bus.REQ    request vector, bit i = source i (A..D)
//   bus.A..D   data sources forwarded through the mux
//   bus.GNT    registered one-hot grant, zero when idle
//   bus.S0/S1  registered mux selects, index i -> S0=i[1], S1=i[0]
//   bus.OUT    granted source bit, 0 whenever BUSY is low
//   bus.BUSY   registered, high while a grant is active
//   bus.LOCK   present only when MUX_ARB_LOCK_EN is defined: suppresses burst preemption
//
// Optional feature macro: MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic           CLK,
  input  logic           RST,
  mux_rr_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic [1:0]    sel_q,   sel_d;
  logic          busy_q,  busy_d;
  logic [1:0]    ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [3:0]    others;
  logic          own_req;
  logic [1:0]    win;
  logic          lock_w;
  logic          mux_bit;

`ifdef MUX_ARB_LOCK_EN
  assign lock_w = bus.LOCK;
`else
  assign lock_w = 1'b0;
`endif

  // First set bit of req, searching upward from ptr+1 and wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // In GRANT gnt_q is the one-hot of the current owner, so masking with it
  // both excludes the owner on preemption and leaves REQ untouched in IDLE.
  assign others  = bus.REQ & ~gnt_q;
  assign own_req = |(bus.REQ & gnt_q);
  // PTR always equals the current owner, so the search start is PTR+1 in every case.
  assign win     = rr_pick(others, ptr_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          ptr_d   = win;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (!own_req) begin
          if (|others) begin
            // Owner released while others wait: hand off on this same edge.
            gnt_d  = 4'b0001 << win;
            sel_d  = win;
            ptr_d  = win;
            cnt_d  = '0;
          end else begin
            // Selects keep their last value so the mux input does not move.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q == CNT_TOP) begin
          if (lock_w) begin
            // Locked burst: park the counter at the limit so release rotates at once.
            cnt_d = CNT_TOP;
          end else if (|others) begin
            gnt_d  = 4'b0001 << win;
            sel_d  = win;
            ptr_d  = win;
            cnt_d  = '0;
          end else begin
            // Nobody else waiting: restart the burst window, grant unchanged.
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // The mux itself: {S0,S1} = 00 A, 01 B, 10 C, 11 D.
  always_comb begin
    case (sel_q)
      2'b00:   mux_bit = bus.A;
      2'b01:   mux_bit = bus.B;
      2'b10:   mux_bit = bus.C;
      default: mux_bit = bus.D;
    endcase
  end

  assign bus.GNT  = gnt_q;
  assign bus.S0   = sel_q[1];
  assign bus.S1   = sel_q[0];
  assign bus.BUSY = busy_q;
  assign bus.OUT  = busy_q & mux_bit;

  // Structural invariants: grant is one-hot or zero, BUSY mirrors it, and the
  // selects always point at the granted source.
  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(gnt_q));
  a_busy_match: assert property (@(posedge CLK) disable iff (RST) busy_q == (|gnt_q));
  a_sel_match:  assert property (@(posedge CLK) disable iff (RST)
                                 busy_q |-> (gnt_q == (4'b0001 << sel_q)));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;

  mux_rr_arbiter_if bus_if();

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {GNT[3:0], S0, S1, BUSY, OUT} after the next rising edge.
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp;
  int         n_fail;

  // Drive one cycle of stimulus on the falling edge and queue what must
  // appear after the following rising edge. dat_v = {D, C, B, A}.
  task automatic cyc(input string tag, input logic rst_v, input logic [3:0] req_v,
                     input logic [3:0] dat_v, input logic [7:0] exp_v);
    @(negedge clk);
    rst        = rst_v;
    bus_if.REQ = req_v;
    bus_if.A   = dat_v[0];
    bus_if.B   = dat_v[1];
    bus_if.C   = dat_v[2];
    bus_if.D   = dat_v[3];
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
  endtask

  // Monitor: one output word per cycle, sampled 1 time unit after the edge.
  initial begin
    logic [7:0] act;
    logic [7:0] exp_v;
    string      tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act   = {bus_if.GNT, bus_if.S0, bus_if.S1, bus_if.BUSY, bus_if.OUT};
        n_cmp++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL %s: {gnt,s0,s1,busy,out} got %b want %b at %0t", tag, act, exp_v, $time);
        end
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus_if.REQ = 4'b0000;
    bus_if.A   = 1'b0;
    bus_if.B   = 1'b0;
    bus_if.C   = 1'b0;
    bus_if.D   = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    bus_if.LOCK = 1'b0;
`endif

    // Reset state, then idle with data toggling: OUT must stay 0.
    cyc("reset0", 1'b1, 4'b0000, 4'b0000, 8'b0000_0000);
    cyc("reset1", 1'b1, 4'b0000, 4'b1111, 8'b0000_0000);
    for (int i = 0; i < 5; i++)
      cyc("idle", 1'b0, 4'b0000, 4'b1111, 8'b0000_0000);

    // Single request C: grant, OUT follows C, release leaves selects at 10.
    cyc("c_grant",  1'b0, 4'b0100, 4'b0100, 8'b0100_1011);
    cyc("c_track",  1'b0, 4'b0100, 4'b0000, 8'b0100_1010);
    cyc("c_drop",   1'b0, 4'b0000, 4'b0100, 8'b0000_1000);

    // Full contention after reset (PTR=3): A,B,C,D four cycles each, then A.
    // Data: B=1, D=1.
    cyc("rr_reset", 1'b1, 4'b0000, 4'b1010, 8'b0000_0000);
    for (int i = 0; i < 4; i++) cyc("rr_a", 1'b0, 4'b1111, 4'b1010, 8'b0001_0010);
    for (int i = 0; i < 4; i++) cyc("rr_b", 1'b0, 4'b1111, 4'b1010, 8'b0010_0111);
    for (int i = 0; i < 4; i++) cyc("rr_c", 1'b0, 4'b1111, 4'b1010, 8'b0100_1010);
    for (int i = 0; i < 4; i++) cyc("rr_d", 1'b0, 4'b1111, 4'b1010, 8'b1000_1111);
    cyc("rr_wrap_a", 1'b0, 4'b1111, 4'b1010, 8'b0001_0010);

    // A keeps its grant, then REQ jumps to D only: direct hand-off, no idle cycle.
    cyc("ho_keep_a", 1'b0, 4'b0001, 4'b1010, 8'b0001_0010);
    cyc("ho_to_d",   1'b0, 4'b1000, 4'b1010, 8'b1000_1111);

    // B alone for 10 cycles: burst counter wraps without disturbing GNT.
    for (int i = 0; i < 10; i++)
      cyc("b_alone", 1'b0, 4'b0010, 4'b0010, 8'b0010_0111);
    cyc("b_drop", 1'b0, 4'b0000, 4'b0010, 8'b0000_0100);

    // Mid-burst reset: PTR=1 so C wins first; reset clears; restart at A.
    cyc("mid_c0",    1'b0, 4'b1111, 4'b1010, 8'b0100_1010);
    cyc("mid_c1",    1'b0, 4'b1111, 4'b1010, 8'b0100_1010);
    cyc("mid_rst",   1'b1, 4'b1111, 4'b1010, 8'b0000_0000);
    cyc("post_rst_a", 1'b0, 4'b1111, 4'b1011, 8'b0001_0011);

`ifdef MUX_ARB_LOCK_EN
    // Locked burst: A held 10 cycles against B, releases on the LOCK drop.
    cyc("lk_reset", 1'b1, 4'b0000, 4'b0001, 8'b0000_0000);
    bus_if.LOCK = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc("lk_hold_a", 1'b0, 4'b0011, 4'b0001, 8'b0001_0011);
    @(negedge clk);
    bus_if.LOCK = 1'b0;
    exp_q.push_back(8'b0010_0110);
    tag_q.push_back("lk_rotate_b");
`endif

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
